framed_bit_tx: RTL and testbench
================================

Name: framed_bit_tx

Overview:
- Parametrised successor to the team's word-to-bit serialiser.
- Buffers DATA_WIDTH-bit words in an internal FIFO and, on a start pulse, emits a framed bit stream: SYNC word, LEN field, payload, CRC-8.
- Adds configurable bit period, backpressure and error reporting.
- Sits between the host/AXI register front-end and the bit-level channel; the receiver strobes on o_tx_valid.

Parameters:
DATA_WIDTH, 32, payload word width; multiple of 8, >=8
FIFO_DEPTH, 16, payload FIFO depth in words; power of 2, >=2
LEN_WIDTH, 8, width of length header and i_data_num
SYNC_WIDTH, 16, sync word width
SYNC_WORD, 16'hD391, sync pattern
BIT_DIV, 1, clocks per transmitted bit; >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_valid  in  1  write strobe for i_data
i_data  in  DATA_WIDTH  payload word
o_ready  out  1  FIFO not full
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  words held
i_data_num  in  LEN_WIDTH  words in next frame, sampled with i_tx_start
i_tx_start  in  1  one-cycle frame start request
o_tx_data  out  1  serial bit
o_tx_valid  out  1  one-cycle bit strobe
o_busy  out  1  frame in progress
o_done  out  1  one-cycle frame-complete pulse
o_start_err  out  1  one-cycle start-rejected pulse
o_overflow  out  1  sticky write-dropped flag

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high. On rst: FIFO flushed, state IDLE, all outputs 0 except o_ready=1; o_fifo_count=0. Reset mid-frame aborts the frame with no o_done.
- FIFO write when i_valid && o_ready. i_valid while full: word dropped, o_overflow set; it stays set until rst. Writes are accepted in any state, including during transmission.
- Simultaneous FIFO pop and push in the same cycle: count is unchanged. A word is valid for o_ready 1 cycle after the push.
- Start handling, evaluated in IDLE only:
  - i_data_num==0 or i_data_num>o_fifo_count: start rejected; o_start_err pulses the next cycle; stay IDLE.
  - Otherwise N is latched and the frame starts.
  - i_tx_start while busy is ignored, with no error pulse.
- States: IDLE -> SYNC -> LEN -> PAYLOAD -> CRC -> DONE -> IDLE.
- Field order:
  - SYNC: SYNC_WORD, MSB first.
  - LEN: N, MSB first.
  - PAYLOAD: N words, popped one per word at the first bit of that word. Within each word, byte 0 (bits[7:0]) first, ascending bytes, each byte MSB first.
  - CRC: 8 bits, MSB first.
- CRC-8: poly 0x07, init 0x00, no reflection, no final XOR. It covers the LEN and PAYLOAD bits in transmit order. Check value: "123456789" gives 0xF4.
- Timing: if start is accepted at cycle T, o_busy=1 from T+1, and the first bit strobe is at T+1. Each bit holds o_tx_data for BIT_DIV cycles, with o_tx_valid high only in the first cycle of the period. Strobe k (k from 0) is at T+1+k*BIT_DIV.
- Frame bit count F = SYNC_WIDTH + LEN_WIDTH + N*DATA_WIDTH + 8.
- End of frame: DONE is reached at T+1+F*BIT_DIV. There o_done=1 and o_busy=0, and IDLE follows the next cycle. A start accepted on the cycle after o_done begins normally.
- o_tx_data=0 whenever not busy.
- Words left in the FIFO beyond N remain queued for later frames.

Test Plan:
1. Push 0x04030201, 0x08070605; N=2; start with BIT_DIV=1 -> 96 strobes on consecutive cycles. Bits: D391, 02, bytes 01..08, CRC 0xCC. o_done at T+97. o_fifo_count goes 2 -> 0.
2. BIT_DIV=4, one word 0xA5A5A5A5, N=1 -> 64 strobes spaced 4 cycles apart; o_tx_data is stable across each 4-cycle period; o_busy is high for 256 cycles.
3. N=3 with 2 words queued, and separately N=0 -> o_start_err pulse, no strobes, FIFO untouched. Then N=2 -> normal frame.
4. Push 17 words with FIFO_DEPTH=16 -> o_ready=0 after the 16th, the 17th is dropped, o_overflow=1, count=16. Frame N=16 -> payload order matches the first 16 writes.
5. Write 2 words mid-frame, and pulse i_tx_start mid-frame -> no disturbance to the current frame; a start after o_done sends the new words.
6. Assert rst during PAYLOAD -> next cycle all outputs 0, o_fifo_count=0, o_ready=1, no o_done. A subsequent frame is correct.

Source files
------------

// File: rtl/framed_bit_tx.sv
// framed_bit_tx: FIFO-buffered serialiser emitting SYNC, LEN, payload and CRC-8 frames
module framed_bit_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH = 8,
  parameter int SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = 16'hD391,
  parameter int BIT_DIV = 1
) (
  input logic clk,
  input logic rst,
  input logic i_valid,
  input logic [DATA_WIDTH-1:0] i_data,
  output logic o_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  input logic [LEN_WIDTH-1:0] i_data_num,
  input logic i_tx_start,
  output logic o_tx_data,
  output logic o_tx_valid,
  output logic o_busy,
  output logic o_done,
  output logic o_start_err,
  output logic o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int M1 = SYNC_WIDTH > LEN_WIDTH ? SYNC_WIDTH : LEN_WIDTH;
  localparam int M2 = M1 > DATA_WIDTH ? M1 : DATA_WIDTH;
  localparam int SW = M2 > 8 ? M2 : 8;
  localparam int LW = $clog2(SW + 1);
  localparam int DW = $clog2(BIT_DIV + 1);
  typedef enum logic [2:0] {IDLE, SYNC, LEN, PAYLOAD, CRC, DONE} state_t;
  state_t state, nstate;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] word;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] sh, ld;
  logic [LW-1:0] left, ld_left;
  logic [DW-1:0] div;
  logic [LEN_WIDTH-1:0] num, wrd_left;
  logic [7:0] crc, crc_upd;
  logic push, pop, tick, adv, accept, in_crc, bit_nxt;
  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_swap
    assign word[DATA_WIDTH-1-8*b -: 8] = mem[rd_ptr][8*b +: 8];
  end
  assign o_ready = o_fifo_count != CW'(FIFO_DEPTH);
  assign push = i_valid && o_ready;
  assign tick = div == DW'(BIT_DIV - 1);
  assign accept = state == IDLE && i_tx_start && i_data_num != '0 && 32'(i_data_num) <= 32'(o_fifo_count);
  assign adv = state == IDLE ? accept : state != DONE && tick && left == '0;
  assign nstate = state == IDLE ? SYNC : state == SYNC ? LEN : state == CRC ? DONE :
                  (state == PAYLOAD && wrd_left == '0) ? CRC : PAYLOAD;
  assign ld = nstate == SYNC ? SW'(SYNC_WORD) << (SW - SYNC_WIDTH) :
              nstate == LEN ? SW'(num) << (SW - LEN_WIDTH) :
              nstate == PAYLOAD ? SW'(word) << (SW - DATA_WIDTH) : SW'(crc) << (SW - 8);
  assign ld_left = LW'(nstate == SYNC ? SYNC_WIDTH - 1 : nstate == LEN ? LEN_WIDTH - 1 :
                       nstate == PAYLOAD ? DATA_WIDTH - 1 : 7);
  assign pop = adv && nstate == PAYLOAD;
  assign in_crc = nstate == LEN || nstate == PAYLOAD;
  assign bit_nxt = adv ? ld[SW-1] : sh[SW-1];
  assign crc_upd = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_nxt}} & 8'h07);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fifo_count <= '0;
      sh <= '0;
      left <= '0;
      div <= '0;
      num <= '0;
      wrd_left <= '0;
      crc <= '0;
      o_tx_data <= 1'b0;
      o_tx_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_start_err <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      o_fifo_count <= o_fifo_count + CW'(push) - CW'(pop);
      o_overflow <= o_overflow | (i_valid & ~o_ready);
      o_start_err <= state == IDLE && i_tx_start && !accept;
      o_done <= 1'b0;
      o_tx_valid <= 1'b0;
      if (adv) begin
        state <= nstate;
        sh <= ld << 1;
        left <= ld_left;
        div <= '0;
        o_tx_valid <= nstate != DONE;
        o_tx_data <= nstate != DONE && ld[SW-1];
        o_busy <= nstate != DONE;
        o_done <= nstate == DONE;
        if (state == IDLE) num <= i_data_num;
        crc <= state == IDLE ? 8'h00 : in_crc ? crc_upd : crc;
        if (state == LEN) wrd_left <= num - 1'b1;
        else if (pop) wrd_left <= wrd_left - 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          sh <= sh << 1;
          left <= left - 1'b1;
          o_tx_valid <= 1'b1;
          o_tx_data <= sh[SW-1];
          if (state == LEN || state == PAYLOAD) crc <= crc_upd;
        end
      end
    end
  end
endmodule

// File: tb/tb_framed_bit_tx.sv
// tb_framed_bit_tx: directed self-checking bench for framed_bit_tx
module tb_framed_bit_tx;
  logic clk = 0, rst = 1, sel = 0, valid = 0, start = 0;
  logic [31:0] data = 0;
  logic [7:0] num = 0;
  logic rdy1, rdy4, txd1, txd4, txv1, txv4, bsy1, bsy4, dn1, dn4, se1, se4, ov1, ov4;
  logic [4:0] cnt1, cnt4;
  logic ready, txd, txv, busy, done, serr, ovf;
  logic [4:0] count;
  logic [31:0] mq[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign ready = sel ? rdy4 : rdy1;
  assign txd = sel ? txd4 : txd1;
  assign txv = sel ? txv4 : txv1;
  assign busy = sel ? bsy4 : bsy1;
  assign done = sel ? dn4 : dn1;
  assign serr = sel ? se4 : se1;
  assign ovf = sel ? ov4 : ov1;
  assign count = sel ? cnt4 : cnt1;
  framed_bit_tx dut1 (
    .clk(clk), .rst(rst), .i_valid(valid && !sel), .i_data(data), .o_ready(rdy1),
    .o_fifo_count(cnt1), .i_data_num(num), .i_tx_start(start && !sel), .o_tx_data(txd1),
    .o_tx_valid(txv1), .o_busy(bsy1), .o_done(dn1), .o_start_err(se1), .o_overflow(ov1)
  );
  framed_bit_tx #(.BIT_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(valid && sel), .i_data(data), .o_ready(rdy4),
    .o_fifo_count(cnt4), .i_data_num(num), .i_tx_start(start && sel), .o_tx_data(txd4),
    .o_tx_valid(txv4), .o_busy(bsy4), .o_done(dn4), .o_start_err(se4), .o_overflow(ov4)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] w);
    valid = 1;
    data = w;
    if (mq.size() < 16) mq.push_back(w);
    @(negedge clk);
    valid = 0;
  endtask
  task automatic reject(input int n);
    start = 1;
    num = 8'(n);
    @(negedge clk);
    start = 0;
    chk("start_err_pulse", serr, 1);
    chk("reject_busy", busy, 0);
    @(negedge clk);
    chk("start_err_one_cycle", serr, 0);
    chk("reject_no_strobe", txv, 0);
    chk("reject_count", count, mq.size());
  endtask
  task automatic frame(input int n, input int d, input int inj, output logic [7:0] gc);
    logic [7:0] fb[$];
    logic [1023:0] got_v;
    logic [31:0] w;
    logic [7:0] c;
    logic lastb;
    int f, j, k, busy_n, gap_err, hold_err, idle_err, err_n, done_at, bad;
    fb.push_back(8'hD3);
    fb.push_back(8'h91);
    fb.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = mq.pop_front();
      for (int b = 0; b < 4; b++) fb.push_back(w[8*b +: 8]);
    end
    c = 0;
    for (int i = 2; i < fb.size(); i++) begin
      c = c ^ fb[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    fb.push_back(c);
    f = fb.size() * 8;
    got_v = '0;
    j = 1; k = 0; busy_n = 0; gap_err = 0; hold_err = 0; idle_err = 0; err_n = 0; done_at = 0;
    lastb = 0;
    start = 1;
    num = 8'(n);
    @(negedge clk);
    start = 0;
    while (done_at == 0 && j < 4000) begin
      if (txv) begin
        if (j != 1 + k * d) gap_err++;
        if (k < 1024) got_v[k] = txd;
        lastb = txd;
        k++;
      end else if (busy && txd !== lastb) hold_err++;
      if (!busy && txd !== 1'b0) idle_err++;
      if (busy) busy_n++;
      if (serr) err_n++;
      if (done) done_at = j;
      valid = inj != 0 && (j == inj || j == inj + 1);
      data = j == inj ? 32'hCAFE0001 : 32'hCAFE0002;
      if (valid) mq.push_back(data);
      start = inj != 0 && j == inj + 2;
      @(negedge clk);
      j++;
    end
    valid = 0;
    start = 0;
    bad = -1;
    for (int i = f - 1; i >= 0; i--) if (got_v[i] !== fb[i / 8][7 - i % 8]) bad = i;
    gc = 0;
    for (int i = 0; i < 8; i++) gc[7 - i] = got_v[f - 8 + i];
    chk("done_cycle", done_at, 1 + f * d);
    chk("strobe_count", k, f);
    chk("first_bad_bit", bad, -1);
    chk("strobe_spacing_errs", gap_err, 0);
    chk("hold_errs", hold_err, 0);
    chk("busy_cycles", busy_n, f * d);
    chk("idle_data_errs", idle_err, 0);
    chk("start_err_in_frame", err_n, 0);
    chk("done_one_cycle", done, 0);
    chk("fifo_count_after", count, mq.size());
  endtask
  initial begin
    logic [7:0] gc;
    int dn_n;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txv", txv, 0);
    chk("rst_txd", txd, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 0;
    @(negedge clk);
    push(32'h04030201);
    push(32'h08070605);
    chk("t1_count_before", count, 2);
    frame(2, 1, 0, gc);
    chk("t1_crc", gc, 8'hCC);
    chk("t1_count_after", count, 0);
    sel = 1;
    push(32'hA5A5A5A5);
    frame(1, 4, 0, gc);
    sel = 0;
    @(negedge clk);
    push(32'h11111111);
    push(32'h22222222);
    reject(3);
    reject(0);
    frame(2, 1, 0, gc);
    for (int i = 0; i < 16; i++) push(32'h10000000 + i);
    chk("t4_ready_full", ready, 0);
    chk("t4_count_full", count, 16);
    chk("t4_ovf_before", ovf, 0);
    push(32'hDEADBEEF);
    chk("t4_ovf_set", ovf, 1);
    chk("t4_count_after_drop", count, 16);
    frame(16, 1, 0, gc);
    chk("t4_ovf_sticky", ovf, 1);
    push(32'h33333333);
    push(32'h44444444);
    frame(2, 1, 30, gc);
    chk("t5_queued", count, 2);
    frame(2, 1, 0, gc);
    push(32'h55555555);
    push(32'h66666666);
    start = 1;
    num = 2;
    @(negedge clk);
    start = 0;
    repeat (29) @(negedge clk);
    chk("t6_busy_before_rst", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6_txd", txd, 0);
    chk("t6_txv", txv, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_serr", serr, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_count", count, 0);
    chk("t6_ready", ready, 1);
    dn_n = 0;
    repeat (200) begin
      @(negedge clk);
      if (done || txv) dn_n++;
    end
    chk("t6_no_done_or_strobe", dn_n, 0);
    mq.delete();
    push(32'h77777777);
    frame(1, 1, 0, gc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
